control_sequencer: RTL and testbench

Multi-cycle control unit sitting directly upstream of the register-file/ALU/RAM datapath. Holds the program counter, fetches 32-bit LEGv8-subset instructions from a combinational instruction ROM, decodes them, and drives the datapath control word (DA, SA, SB, K, BS, FS, regW, ramW, selEN). It consumes the datapath's 4-bit ALU status to resolve conditional branches.

---
 rtl/control_sequencer_pkg.sv | 50 +++++
 rtl/control_sequencer_decode.sv | 68 ++++++
 rtl/control_sequencer.sv | 107 ++++++++++
 tb/tb_control_sequencer.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/control_sequencer_pkg.sv
// Shared constants and types for the control sequencer: opcodes, ALU function
// selects, status flag positions, FSM states and the decoded control word.
package control_pkg;

    // R-format / D-format 11-bit opcodes, ir[31:21]
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    // I-format 10-bit opcodes, ir[31:22]
    localparam logic [9:0]  OP_ADDI = 10'b1001000100;
    localparam logic [9:0]  OP_SUBI = 10'b1101000100;
    // CB-format 8-bit opcodes, ir[31:24]
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;
    localparam logic [7:0]  OP_CBNZ = 8'b10110101;
    // B-format 6-bit opcode, ir[31:26]
    localparam logic [5:0]  OP_B    = 6'b000101;

    localparam logic [4:0]  FS_AND  = 5'b00000;
    localparam logic [4:0]  FS_ORR  = 5'b00100;
    localparam logic [4:0]  FS_ADD  = 5'b01000;
    localparam logic [4:0]  FS_SUB  = 5'b01001;

    // status = {V,C,N,Z}
    localparam int ST_Z = 0;
    localparam int ST_N = 1;
    localparam int ST_C = 2;
    localparam int ST_V = 3;

    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

    typedef enum logic [2:0] {
        C_ALU, C_STORE, C_LOAD, C_B, C_CBZ, C_CBNZ, C_HALT, C_ILL
    } iclass_t;

    typedef struct packed {
        logic [4:0]  da;
        logic [4:0]  sa;
        logic [4:0]  sb;
        logic [63:0] k;
        logic        bs;
        logic [4:0]  fs;
        logic        regw;
        logic        ramw;
        logic        selen;
    } ctrl_t;

endpackage

// File: rtl/control_sequencer_decode.sv
// Combinational instruction decoder: ir -> control word, instruction class and
// pre-scaled, sign-extended branch offset. Carries no state.
module instr_decode
    import control_pkg::*;
#(
    parameter int PC_W = 64
) (
    input  logic [31:0]     ir,
    output ctrl_t           ctrl,
    output iclass_t         cls,
    output logic [PC_W-1:0] br_off
);

    // Decode by opcode width; the all-zero word is checked first as HALT.
    always_comb begin
        ctrl   = '0;
        cls    = C_ILL;
        br_off = '0;
        if (ir == 32'h0000_0000) begin
            cls = C_HALT;
        end else if (ir[31:21] == OP_ADD || ir[31:21] == OP_SUB ||
                     ir[31:21] == OP_AND || ir[31:21] == OP_ORR) begin
            cls        = C_ALU;
            ctrl.da    = ir[4:0];
            ctrl.sa    = ir[9:5];
            ctrl.sb    = ir[20:16];
            ctrl.regw  = 1'b1;
            ctrl.selen = 1'b1;
            case (ir[31:21])
                OP_ADD:  ctrl.fs = FS_ADD;
                OP_SUB:  ctrl.fs = FS_SUB;
                OP_AND:  ctrl.fs = FS_AND;
                default: ctrl.fs = FS_ORR;
            endcase
        end else if (ir[31:22] == OP_ADDI || ir[31:22] == OP_SUBI) begin
            cls        = C_ALU;
            ctrl.da    = ir[4:0];
            ctrl.sa    = ir[9:5];
            ctrl.k     = {52'd0, ir[21:10]};
            ctrl.bs    = 1'b1;
            ctrl.fs    = (ir[31:22] == OP_ADDI) ? FS_ADD : FS_SUB;
            ctrl.regw  = 1'b1;
            ctrl.selen = 1'b1;
        end else if (ir[31:21] == OP_STUR || ir[31:21] == OP_LDUR) begin
            // Address generation Rn + sext(imm9) is shared by load and store.
            // DA carries Rt for the load so the MEM write-back can reuse it.
            cls       = (ir[31:21] == OP_STUR) ? C_STORE : C_LOAD;
            ctrl.sa   = ir[9:5];
            ctrl.sb   = ir[4:0];
            ctrl.k    = {{55{ir[20]}}, ir[20:12]};
            ctrl.bs   = 1'b1;
            ctrl.fs   = FS_ADD;
            ctrl.ramw = (ir[31:21] == OP_STUR);
            ctrl.da   = (ir[31:21] == OP_LDUR) ? ir[4:0] : 5'd0;
        end else if (ir[31:26] == OP_B) begin
            cls    = C_B;
            br_off = {{(PC_W-28){ir[25]}}, ir[25:0], 2'b00};
        end else if (ir[31:24] == OP_CBZ || ir[31:24] == OP_CBNZ) begin
            // Rt + 0 through the ALU so Z reflects the tested register.
            cls     = (ir[31:24] == OP_CBZ) ? C_CBZ : C_CBNZ;
            ctrl.sa = ir[4:0];
            ctrl.bs = 1'b1;
            ctrl.fs = FS_ADD;
            br_off  = {{(PC_W-21){ir[23]}}, ir[23:5], 2'b00};
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle FETCH/EXEC/MEM/HALT sequencer. Owns pc, ir, state and the sticky
// illegal flag; gates the decoded control word by state so write enables only
// appear in EXEC/MEM.
module control_sequencer
    import control_pkg::*;
#(
    parameter int PC_W = 64
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [31:0]     instr,
    input  logic [3:0]      status,
    output logic [PC_W-1:0] pc,
    output logic [4:0]      DA,
    output logic [4:0]      SA,
    output logic [4:0]      SB,
    output logic [63:0]     K,
    output logic            BS,
    output logic [4:0]      FS,
    output logic            regW,
    output logic            ramW,
    output logic            selEN,
    output logic            halted,
    output logic            illegal
);

    localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);

    state_t          state;
    logic [31:0]     ir;
    ctrl_t           dec;
    iclass_t         cls;
    logic [PC_W-1:0] br_off;
    ctrl_t           ctrl;

    instr_decode #(.PC_W(PC_W)) u_dec (
        .ir     (ir),
        .ctrl   (dec),
        .cls    (cls),
        .br_off (br_off)
    );

    // State, pc, ir and illegal update; branches resolve on status this cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= S_FETCH;
            pc      <= '0;
            ir      <= '0;
            illegal <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    ir    <= instr;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    state <= S_FETCH;
                    case (cls)
                        C_LOAD: state <= S_MEM;
                        C_HALT: state <= S_HALT;
                        C_B:    pc    <= pc + br_off;
                        C_CBZ:  pc    <= pc + (status[ST_Z] ? br_off : PC_STEP);
                        C_CBNZ: pc    <= pc + (status[ST_Z] ? PC_STEP : br_off);
                        C_ILL: begin
                            illegal <= 1'b1;
                            pc      <= pc + PC_STEP;
                        end
                        default: pc <= pc + PC_STEP;
                    endcase
                end
                S_MEM: begin
                    pc    <= pc + PC_STEP;
                    state <= S_FETCH;
                end
                default: state <= S_HALT;
            endcase
        end
    end

    // Control word is live only in EXEC and MEM; MEM turns the load into a
    // RAM-sourced register write while keeping the address path steady.
    always_comb begin
        ctrl = '0;
        case (state)
            S_EXEC: ctrl = dec;
            S_MEM: begin
                ctrl       = dec;
                ctrl.regw  = 1'b1;
                ctrl.ramw  = 1'b0;
                ctrl.selen = 1'b0;
            end
            default: ctrl = '0;
        endcase
    end

    assign DA     = ctrl.da;
    assign SA     = ctrl.sa;
    assign SB     = ctrl.sb;
    assign K      = ctrl.k;
    assign BS     = ctrl.bs;
    assign FS     = ctrl.fs;
    assign regW   = ctrl.regw;
    assign ramW   = ctrl.ramw;
    assign selEN  = ctrl.selen;
    assign halted = (state == S_HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: small ROM model, hand-computed expects.
module tb_control_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instr;
    logic [3:0]  status = 4'b0000;
    logic [63:0] pc;
    logic [4:0]  DA, SA, SB, FS;
    logic [63:0] K;
    logic        BS, regW, ramW, selEN, halted, illegal;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] rom [0:63];

    localparam logic [31:0] I_ADDI = {10'b1001000100, 12'd5, 5'd31, 5'd1};
    localparam logic [31:0] I_LDUR = {11'b11111000010, 9'h1F8, 2'b00, 5'd1, 5'd2};
    localparam logic [31:0] I_SUB  = {11'b11001011000, 5'd6, 6'd0, 5'd5, 5'd4};
    localparam logic [31:0] I_STUR = {11'b11111000000, 9'd16, 2'b00, 5'd8, 5'd7};
    localparam logic [31:0] I_CBZ  = {8'b10110100, 19'd4, 5'd3};
    localparam logic [31:0] I_BM1  = {6'b000101, 26'h3FF_FFFF};

    assign instr = rom[pc[7:2]];

    control_sequencer #(.PC_W(64)) dut (
        .clock(clock), .reset(reset), .instr(instr), .status(status),
        .pc(pc), .DA(DA), .SA(SA), .SB(SB), .K(K), .BS(BS), .FS(FS),
        .regW(regW), .ramW(ramW), .selEN(selEN), .halted(halted),
        .illegal(illegal)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            @(negedge clock);
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 64; i++) rom[i] = 32'h0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        // ---- ALU, load, store sequence ----
        clear_rom();
        rom[0] = I_ADDI; rom[1] = I_LDUR; rom[2] = I_SUB; rom[3] = I_STUR;
        do_reset();
        check("rst_pc", pc, 64'd0);
        check("rst_regW", {63'd0, regW}, 64'd0);
        check("rst_halted", {63'd0, halted}, 64'd0);
        check("rst_illegal", {63'd0, illegal}, 64'd0);
        check("rst_K", K, 64'd0);

        step(1);
        check("addi_DA", {59'd0, DA}, 64'd1);
        check("addi_SA", {59'd0, SA}, 64'd31);
        check("addi_K", K, 64'd5);
        check("addi_BS", {63'd0, BS}, 64'd1);
        check("addi_FS", {59'd0, FS}, 64'h08);
        check("addi_regW", {63'd0, regW}, 64'd1);
        check("addi_selEN", {63'd0, selEN}, 64'd1);
        check("addi_pc_hold", pc, 64'd0);
        step(1);
        check("addi_pc", pc, 64'd4);
        check("fetch_regW", {63'd0, regW}, 64'd0);

        step(1);
        check("ldur_K", K, 64'hFFFF_FFFF_FFFF_FFF8);
        check("ldur_ex_regW", {63'd0, regW}, 64'd0);
        check("ldur_ex_ramW", {63'd0, ramW}, 64'd0);
        check("ldur_SA", {59'd0, SA}, 64'd1);
        step(1);
        check("ldur_mem_regW", {63'd0, regW}, 64'd1);
        check("ldur_mem_selEN", {63'd0, selEN}, 64'd0);
        check("ldur_mem_DA", {59'd0, DA}, 64'd2);
        check("ldur_mem_K", K, 64'hFFFF_FFFF_FFFF_FFF8);
        check("ldur_mem_pc", pc, 64'd4);
        step(1);
        check("ldur_pc", pc, 64'd8);

        step(1);
        check("sub_FS", {59'd0, FS}, 64'h09);
        check("sub_regs", {49'd0, DA, SA, SB}, {49'd0, 5'd4, 5'd5, 5'd6});
        check("sub_BS", {63'd0, BS}, 64'd0);
        step(2);
        check("stur_K", K, 64'd16);
        check("stur_regs", {54'd0, SA, SB}, {54'd0, 5'd8, 5'd7});
        check("stur_ramW", {63'd0, ramW}, 64'd1);
        check("stur_regW", {63'd0, regW}, 64'd0);
        step(1);
        check("stur_pc", pc, 64'h10);

        // ---- reset during MEM of LDUR ----
        do_reset();
        step(4);
        check("mem2_regW", {63'd0, regW}, 64'd1);
        #2 reset = 1'b1;
        #1;
        check("rstmem_regW", {63'd0, regW}, 64'd0);
        check("rstmem_pc", pc, 64'd0);
        @(negedge clock);
        reset = 1'b0;
        step(1);
        check("refetch_DA", {59'd0, DA}, 64'd1);
        check("refetch_pc", pc, 64'd0);

        // ---- CBZ taken / not taken at pc=0x10 ----
        clear_rom();
        for (int i = 0; i < 4; i++) rom[i] = I_ADDI;
        rom[4] = I_CBZ;
        status = 4'b0001;
        do_reset();
        step(8);
        check("cbz_at", pc, 64'h10);
        step(1);
        check("cbz_SA", {59'd0, SA}, 64'd3);
        check("cbz_K", K, 64'd0);
        check("cbz_BS", {63'd0, BS}, 64'd1);
        check("cbz_regW", {63'd0, regW}, 64'd0);
        step(1);
        check("cbz_taken_pc", pc, 64'h20);
        status = 4'b0000;
        do_reset();
        step(10);
        check("cbz_nt_pc", pc, 64'h14);

        // ---- B backwards and wrap ----
        clear_rom();
        rom[0] = I_ADDI; rom[1] = I_ADDI; rom[2] = I_BM1;
        do_reset();
        step(5);
        check("b_ex_regW", {63'd0, regW | ramW}, 64'd0);
        step(1);
        check("b_back_pc", pc, 64'h4);
        clear_rom();
        rom[0] = I_BM1;
        do_reset();
        step(2);
        check("b_wrap_pc", pc, 64'hFFFF_FFFF_FFFF_FFFC);

        // ---- illegal then HALT ----
        clear_rom();
        rom[0] = 32'hFFFF_FFFF;
        do_reset();
        step(1);
        check("ill_ex_we", {62'd0, regW, ramW}, 64'd0);
        step(1);
        check("ill_flag", {63'd0, illegal}, 64'd1);
        check("ill_pc", pc, 64'd4);
        step(1);
        check("halt_ex_halted", {63'd0, halted}, 64'd0);
        step(1);
        check("halted", {63'd0, halted}, 64'd1);
        for (int i = 0; i < 10; i++) begin
            step(1);
            check("halt_pc", pc, 64'd4);
            check("halt_state", {61'd0, halted, illegal, regW}, {61'd0, 1'b1, 1'b1, 1'b0});
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
